// File: rtl/clk_lock_manager.sv
// PLL lock supervisor: qualifies a raw lock, drives a sync-deassert reset/ready, and emits phase-aligned clock enables.
// Optional macro LOCK_GLITCH_FILTER_EN adds a 4-sample agreement filter after the synchroniser.
module clk_lock_manager #(
    parameter int NUM_CH             = 2,
    parameter int DIV_W              = 16,
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int HOLDOFF_CYCLES     = 64,
    parameter int LOSS_CNT_W         = 8
) (
    input  logic                    clock_in,
    input  logic                    reset_n,
    input  logic                    locked_in,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    input  logic                    div_load,
    input  logic                    clr_lost,
    output logic                    rst_out_n,
    output logic                    ready,
    output logic [NUM_CH-1:0]       ce_out,
    output logic                    lock_lost,
    output logic [LOSS_CNT_W-1:0]   loss_count
);

    localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_LOCK, STABILIZE, RUN, HOLDOFF} state_t;

    state_t                   state;
    state_t                   next_state;
    logic                     loss_event;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     lock_sync;
    logic [STAB_W-1:0]        stab_cnt;
    logic [HOLD_W-1:0]        hold_cnt;
    logic [DIV_W-1:0]         ratio_q [NUM_CH];
    logic [DIV_W-1:0]         cnt_q   [NUM_CH];
    logic [DIV_W-1:0]         term    [NUM_CH];
    logic                     run_hold;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], locked_in};
    end

`ifdef LOCK_GLITCH_FILTER_EN
    logic [2:0] hist_q;
    logic       filt_q;
    logic       sync_raw;

    assign sync_raw = sync_q[SYNC_STAGES-1];

    // Output follows the input only once four consecutive samples agree.
    always_comb begin
        if (&{hist_q, sync_raw})       lock_sync = 1'b1;
        else if (~|{hist_q, sync_raw}) lock_sync = 1'b0;
        else                           lock_sync = filt_q;
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[1:0], sync_raw};
            filt_q <= lock_sync;
        end
    end
`else
    assign lock_sync = sync_q[SYNC_STAGES-1];
`endif

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        loss_event = 1'b0;
        case (state)
            WAIT_LOCK: if (lock_sync) next_state = STABILIZE;
            STABILIZE: begin
                if (!lock_sync)                 next_state = WAIT_LOCK;
                else if (stab_cnt == STAB_LAST) next_state = RUN;
            end
            RUN: begin
                if (!lock_sync) begin
                    next_state = HOLDOFF;
                    loss_event = 1'b1;
                end
            end
            HOLDOFF:   if (hold_cnt == HOLD_LAST) next_state = WAIT_LOCK;
            default:   next_state = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT_LOCK;
            stab_cnt   <= '0;
            hold_cnt   <= '0;
            rst_out_n  <= 1'b0;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
            loss_count <= '0;
        end else begin
            state     <= next_state;
            rst_out_n <= (next_state == RUN);
            ready     <= (next_state == RUN);
            stab_cnt  <= (state == STABILIZE && next_state == STABILIZE) ? stab_cnt + STAB_W'(1) : '0;
            hold_cnt  <= (state == HOLDOFF && next_state == HOLDOFF) ? hold_cnt + HOLD_W'(1) : '0;
            if (loss_event)    lock_lost <= 1'b1;
            else if (clr_lost) lock_lost <= 1'b0;
            if (loss_event && loss_count != '1) loss_count <= loss_count + LOSS_CNT_W'(1);
        end
    end

    // A ratio of zero behaves as one.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            term[i] = (ratio_q[i] == '0) ? '0 : ratio_q[i] - DIV_W'(1);
    end

    assign run_hold = (state == RUN) && (next_state == RUN) && !div_load;

    // NOTE: the ratio registers are real state with a defined power-up value, so they are reset like any flop.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            ce_out <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ratio_q[i] <= DIV_W'(1);
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (div_load) ratio_q[i] <= div_ratio[i*DIV_W +: DIV_W];
                if (run_hold && cnt_q[i] == term[i]) begin
                    cnt_q[i]  <= '0;
                    ce_out[i] <= 1'b1;
                end else if (run_hold) begin
                    cnt_q[i]  <= cnt_q[i] + DIV_W'(1);
                    ce_out[i] <= 1'b0;
                end else begin
                    cnt_q[i]  <= '0;
                    ce_out[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_lock_manager.sv
// Self-checking bench for clk_lock_manager: directed scenarios, then random lock/ratio traffic against a behavioural model.
module tb_clk_lock_manager;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 16;
    localparam int SYNC   = 2;
    localparam int L      = 16;
    localparam int H      = 8;
    localparam int CW     = 2;
`ifdef LOCK_GLITCH_FILTER_EN
    localparam int EXTRA = 3;
`else
    localparam int EXTRA = 0;
`endif
    localparam int DROP         = EXTRA + 1;
    localparam int GLITCH_READY = (EXTRA > 0) ? 1 : 0;

    logic                    clock_in  = 1'b0;
    logic                    reset_n   = 1'b0;
    logic                    locked_in = 1'b0;
    logic [NUM_CH*DIV_W-1:0] div_ratio = '0;
    logic                    div_load  = 1'b0;
    logic                    clr_lost  = 1'b0;
    logic                    rst_out_n;
    logic                    ready;
    logic [NUM_CH-1:0]       ce_out;
    logic                    lock_lost;
    logic [CW-1:0]           loss_count;

    clk_lock_manager #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .SYNC_STAGES(SYNC),
        .LOCK_STABLE_CYCLES(L), .HOLDOFF_CYCLES(H), .LOSS_CNT_W(CW)
    ) dut (
        .clock_in(clock_in), .reset_n(reset_n), .locked_in(locked_in),
        .div_ratio(div_ratio), .div_load(div_load), .clr_lost(clr_lost),
        .rst_out_n(rst_out_n), .ready(ready), .ce_out(ce_out),
        .lock_lost(lock_lost), .loss_count(loss_count)
    );

    always #5 clock_in = ~clock_in;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: lock history queues, a qualifying streak, a holdoff budget and modulo strobes.
    bit          m_run    = 1'b0;
    int          m_hold   = 0;
    int          m_streak = 0;
    int          m_n      = 0;
    bit          m_lost   = 1'b0;
    int          m_count  = 0;
    logic [NUM_CH-1:0] m_ce = '0;
    int          m_ratio [NUM_CH];
    bit          q_sync [$];
    bit          q_filt [$];
    bit          m_filt   = 1'b0;

    task automatic model_reset();
        m_run = 1'b0; m_hold = 0; m_streak = 0; m_n = 0;
        m_lost = 1'b0; m_count = 0; m_ce = '0; m_filt = 1'b0;
        for (int i = 0; i < NUM_CH; i++) m_ratio[i] = 1;
        q_sync = {};
        for (int i = 0; i < SYNC; i++) q_sync.push_back(1'b0);
        q_filt = {1'b0, 1'b0, 1'b0};
    endtask

    task automatic model_step();
        bit raw, ls, next_run, loss;
        int eff;
        raw = q_sync.pop_front();
        q_sync.push_back(locked_in);
`ifdef LOCK_GLITCH_FILTER_EN
        if (q_filt[0] == raw && q_filt[1] == raw && q_filt[2] == raw) m_filt = raw;
        ls = m_filt;
        void'(q_filt.pop_front());
        q_filt.push_back(raw);
`else
        ls = raw;
`endif
        next_run = m_run;
        loss     = 1'b0;
        if (m_run) begin
            if (!ls) begin
                next_run = 1'b0;
                loss     = 1'b1;
                m_hold   = H;
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else begin
            m_streak = ls ? m_streak + 1 : 0;
            if (m_streak == L + 1) begin
                next_run = 1'b1;
                m_streak = 0;
            end
        end
        if (div_load)
            for (int i = 0; i < NUM_CH; i++) m_ratio[i] = int'(div_ratio[i*DIV_W +: DIV_W]);
        if (m_run && next_run && !div_load) begin
            m_n++;
            for (int i = 0; i < NUM_CH; i++) begin
                eff = (m_ratio[i] == 0) ? 1 : m_ratio[i];
                m_ce[i] = ((m_n % eff) == 0);
            end
        end else begin
            m_n  = 0;
            m_ce = '0;
        end
        if (loss)          m_lost = 1'b1;
        else if (clr_lost) m_lost = 1'b0;
        if (loss && m_count < (1 << CW) - 1) m_count++;
        m_run = next_run;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock_in or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_step();
        end
    end

    // Advance one cycle and compare every output against the model.
    task automatic tick();
        @(negedge clock_in);
        check("rst_out_n", 32'(rst_out_n), 32'(m_run));
        check("ready", 32'(ready), 32'(m_run));
        check("ce_out", 32'(ce_out), 32'(m_ce));
        check("lock_lost", 32'(lock_lost), 32'(m_lost));
        check("loss_count", 32'(loss_count), m_count);
    endtask

    // Drop lock while running, then let it re-qualify; literal timing checks along the way.
    task automatic lose_and_recover(input bit clr_on_loss, input bit load_in_holdoff,
                                    input logic [NUM_CH*DIV_W-1:0] ratios);
        locked_in = 1'b0;
        for (int k = 1; k <= 28 + EXTRA; k++) begin
            tick();
            clr_lost = 1'b0;
            div_load = 1'b0;
            if (k == DROP) locked_in = 1'b1;
            if (k == 2 + EXTRA) begin
                check("loss_ready_still_high", 32'(ready), 1);
                if (clr_on_loss) clr_lost = 1'b1;
            end
            if (k == 3 + EXTRA) begin
                check("loss_rst_fell", 32'(rst_out_n), 0);
                check("loss_lock_lost_set", 32'(lock_lost), 1);
            end
            if (k == 5 + EXTRA && load_in_holdoff) begin
                div_ratio = ratios;
                div_load  = 1'b1;
            end
            if (k == 27 + EXTRA) check("rerelease_not_early", 32'(ready), 0);
        end
        check("rerelease_ready", 32'(ready), 1);
    endtask

    int drop_left;

    initial begin
        repeat (3) tick();
        check("reset_rst_out_n", 32'(rst_out_n), 0);
        check("reset_ready", 32'(ready), 0);
        check("reset_ce_out", 32'(ce_out), 0);
        check("reset_loss_count", 32'(loss_count), 0);
        reset_n = 1'b1;
        tick();

        // Release with steady lock.
        locked_in = 1'b1;
        repeat (18 + EXTRA) tick();
        check("release_not_early", 32'(ready), 0);
        check("ce_before_release", 32'(ce_out), 0);
        tick();
        check("release_rst_out_n", 32'(rst_out_n), 1);
        check("release_ready", 32'(ready), 1);
        tick();
        check("ce_default_ratio_one", 32'(ce_out), 3);

        // Asynchronous reset in the middle of RUN.
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({rst_out_n, ready, ce_out}), 0);
        locked_in = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // Unstable lock restarts qualification.
        locked_in = 1'b1;
        repeat (10) tick();
        locked_in = 1'b0;
        repeat (DROP) tick();
        locked_in = 1'b1;
        repeat (18 + EXTRA) tick();
        check("unstable_not_early", 32'(ready), 0);
        tick();
        check("unstable_release", 32'(ready), 1);
        check("unstable_no_loss", 32'(loss_count), 0);

        // Lock loss in RUN with ratios {3,5} loaded during holdoff.
        repeat (5) tick();
        lose_and_recover(1'b0, 1'b1, {16'd5, 16'd3});
        check("loss_count_one", 32'(loss_count), 1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("ce0_ratio3", 32'(ce_out[0]), 32'((k % 3) == 0));
            check("ce1_ratio5", 32'(ce_out[1]), 32'((k % 5) == 0));
        end
        div_ratio = {16'd2, 16'd0};
        div_load  = 1'b1;
        tick();
        div_load = 1'b0;
        check("load_drops_strobe", 32'(ce_out), 0);
        tick(); check("load_phase1", 32'(ce_out), 1);
        tick(); check("load_phase2", 32'(ce_out), 3);
        tick(); check("load_phase3", 32'(ce_out), 1);
        tick(); check("load_phase4", 32'(ce_out), 3);

        // One-cycle dropout in RUN.
        locked_in = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 1) locked_in = 1'b1;
            if (k == 3) check("glitch_ready", 32'(ready), GLITCH_READY);
        end
        check("glitch_recovered", 32'(ready), 1);

        // Clear semantics and saturation.
        clr_lost = 1'b1;
        tick();
        clr_lost = 1'b0;
        check("clr_alone", 32'(lock_lost), 0);
        lose_and_recover(1'b1, 1'b0, '0);
        check("set_wins_over_clr", 32'(lock_lost), 1);
        clr_lost = 1'b1;
        tick();
        clr_lost = 1'b0;
        check("clr_later", 32'(lock_lost), 0);
        lose_and_recover(1'b0, 1'b0, '0);
        lose_and_recover(1'b0, 1'b0, '0);
        check("loss_count_saturated", 32'(loss_count), 3);

        // Random traffic checked cycle by cycle against the model.
        drop_left = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (drop_left > 0) begin
                drop_left--;
                locked_in = (drop_left == 0);
            end else if ($urandom_range(0, 59) == 0) begin
                drop_left = $urandom_range(1, 6);
                locked_in = 1'b0;
            end
            div_load = ($urandom_range(0, 39) == 0);
            if (div_load)
                for (int i = 0; i < NUM_CH; i++) div_ratio[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 7));
            clr_lost = ($urandom_range(0, 29) == 0);
            reset_n  = (c != 1500);
        end
        reset_n  = 1'b1;
        div_load = 1'b0;
        clr_lost = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
